// File: rtl/bcd_seg_driver.sv
// bcd_seg_driver: converts an 8-bit binary value to three BCD digits with a
// sequential double-dabble (one shift per clock). It then scans those digits
// onto a 4-digit common-anode, active-low seven-segment display.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// The hundreds digit blanks when it is zero. The tens digit blanks when both
// hundreds and tens are zero. The ones digit is always shown.
//
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - synchronous active-high reset, overrides everything
//   val  - binary value from the counter
//   seg  - segment cathodes, active-low, {g,f,e,d,c,b,a}
//   an   - digit anodes, active-low, an[0] = ones digit
//   bcd  - last converted value {hundreds, tens, ones}
//   busy - high while a conversion is in progress
module bcd_seg_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  val,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] TickLast = CntW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StIdle, StShift, StUpdate} state_e;

  state_e      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  last_q, last_d;
  logic [11:0] scratch_q, scratch_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] adj;

  logic [CntW-1:0] tick_q, tick_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Double-dabble adjust: any nibble >= 5 gets +3 before the shift.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (scratch_q[i*4 +: 4] >= 4'd5) ? scratch_q[i*4 +: 4] + 4'd3
                                                      : scratch_q[i*4 +: 4];
    end
  end

  // Conversion FSM next state.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cap_d     = cap_q;
    last_d    = last_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (val != last_q) begin
          sr_d      = val;
          cap_d     = val;
          scratch_d = 12'h000;
          cnt_d     = 3'd0;
          state_d   = StShift;
        end
      end
      StShift: begin
        {scratch_d, sr_d} = {adj, sr_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = StUpdate;
      end
      StUpdate: begin
        bcd_d   = scratch_q;
        last_d  = cap_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan timing and registered digit drive.
  always_comb begin
    tick_d = tick_q + 1'b1;
    idx_d  = idx_q;
    if (tick_q == TickLast) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    seg_d = 7'h7F;
    an_d  = 4'b1111;
    unique case (idx_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_code(bcd_q[3:0]);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = seg_code(bcd_q[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) begin
          an_d  = 4'b1111;
          seg_d = 7'h7F;
        end
`endif
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = seg_code(bcd_q[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_q[11:8] == 4'd0) begin
          an_d  = 4'b1111;
          seg_d = 7'h7F;
        end
`endif
      end
      default: begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cap_q     <= '0;
      last_q    <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      tick_q    <= '0;
      idx_q     <= '0;
      seg_q     <= 7'h7F;
      an_q      <= 4'b1111;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cap_q     <= cap_d;
      last_q    <= last_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign bcd  = bcd_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Directed testbench for bcd_seg_driver with SCAN_DIV = 4.
module tb_bcd_seg_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  val;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int total = 0;
  int bad   = 0;

  bcd_seg_driver #(.SCAN_DIV(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .val  (val),
    .seg  (seg),
    .an   (an),
    .bcd  (bcd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive val, then count edges until busy falls (bounded).
  task automatic run_conv(input logic [7:0] v, output int n);
    val = v;
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 40);
  endtask

  // Wait for the first cycle of the ones slot (bounded).
  task automatic sync_slot0();
    logic [3:0] prev;
    int k;
    prev = an;
    k = 0;
    while (!(an == 4'b1110 && prev != 4'b1110) && k < 64) begin
      prev = an;
      step();
      k++;
    end
    chk("scan_sync", 16'(k < 64), 16'd1);
  endtask

  task automatic check_scan(input string tag, input logic [3:0] ea [4],
                            input logic [6:0] es [4]);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_an"}, 16'(an), 16'(ea[i/4]));
      chk({tag, "_seg"}, 16'(seg), 16'(es[i/4]));
      step();
    end
  endtask

  initial begin
    int n;
    logic [3:0] ea [4];
    logic [6:0] es [4];

    // 1. Reset with val = 0x5A pending.
    rst = 1'b1;
    val = 8'h5A;
    step(); step(); step();
    chk("rst_an", 16'(an), 16'h000F);
    chk("rst_seg", 16'(seg), 16'h007F);
    chk("rst_bcd", 16'(bcd), 16'h0000);
    chk("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    step();
    chk("e0_busy", 16'(busy), 16'd1);
    for (int i = 1; i <= 8; i++) step();
    chk("e8_busy", 16'(busy), 16'd1);
    chk("e8_bcd", 16'(bcd), 16'h0000);
    step();
    chk("5a_bcd", 16'(bcd), 16'h0090);
    chk("5a_busy", 16'(busy), 16'd0);

    // 2. Full-range conversions.
    run_conv(8'd0, n);
    chk("zero_bcd", 16'(bcd), 16'h0000);
    run_conv(8'd255, n);
    chk("255_edges", 16'(n), 16'd10);
    chk("255_bcd", 16'(bcd), 16'h0255);
    run_conv(8'd0, n);
    chk("back0_edges", 16'(n), 16'd10);
    chk("back0_bcd", 16'(bcd), 16'h0000);

    // 3. val changes during the third shift cycle.
    val = 8'd37;
    step(); step(); step();
    val = 8'd200;
    for (int i = 3; i <= 9; i++) step();
    chk("37_bcd", 16'(bcd), 16'h0037);
    chk("37_busy", 16'(busy), 16'd0);
    step();
    chk("200_start", 16'(busy), 16'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("hold_37", 16'(bcd), 16'h0037);
    end
    step();
    chk("200_bcd", 16'(bcd), 16'h0200);
    chk("200_busy", 16'(busy), 16'd0);

    // 4. Scan pattern for 128.
    run_conv(8'd128, n);
    chk("128_bcd", 16'(bcd), 16'h0128);
    sync_slot0();
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    es = '{7'h00, 7'h24, 7'h79, 7'h7F};
    check_scan("scan128", ea, es);

    // 5. Leading zeros: blanked only when the feature is built in.
    run_conv(8'd7, n);
    chk("7_bcd", 16'(bcd), 16'h0007);
    sync_slot0();
`ifdef LEADING_ZERO_BLANK_EN
    ea = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    es = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
`else
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    es = '{7'h78, 7'h40, 7'h40, 7'h7F};
`endif
    check_scan("scan7", ea, es);
    run_conv(8'd100, n);
    chk("100_bcd", 16'(bcd), 16'h0100);
    sync_slot0();
    ea = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    es = '{7'h40, 7'h40, 7'h79, 7'h7F};
    check_scan("scan100", ea, es);

    // 6. Reset pulse in the middle of a conversion.
    val = 8'd150;
    step(); step(); step();
    chk("mid_busy", 16'(busy), 16'd1);
    rst = 1'b1;
    step();
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_bcd", 16'(bcd), 16'h0000);
    chk("midrst_an", 16'(an), 16'h000F);
    chk("midrst_seg", 16'(seg), 16'h007F);
    rst = 1'b0;
    run_conv(8'd150, n);
    chk("150_edges", 16'(n), 16'd10);
    chk("150_bcd", 16'(bcd), 16'h0150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
